hamming_encoder_74_tx: RTL and testbench



---
 rtl/hamming_encoder_74_tx_if.sv | 17 +
 rtl/hamming_encoder_74_tx.sv | 162 ++++++++++++++++
 tb/tb_hamming_encoder_74_tx.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hamming_encoder_74_tx_if.sv
// rtl/hamming_encoder_74_tx_if.sv - nibble handshake bundle for the Hamming(7,4) transmitter
//
// Purpose: groups the upstream nibble handshake into one port.
// Signals:
//   data_in    [3:0] nibble to encode, data_in[0]=d1 .. data_in[3]=d4
//   data_valid       upstream offers data_in this cycle
//   data_ready       transmitter can take a nibble this cycle
// Modports: master = upstream producer, slave = transmitter.

interface hamming_encoder_74_tx_if;
  logic [3:0] data_in;
  logic       data_valid;
  logic       data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/hamming_encoder_74_tx.sv
// rtl/hamming_encoder_74_tx.sv - Hamming(7,4) encoder with UART-style serial transmitter
//
// Purpose: buffers one nibble in a holding register, encodes it into a 7-bit
// Hamming codeword and sends start bit, codeword LSB first, then stop bit(s).
// A second nibble may be queued while a frame is on the wire so frames run
// back to back with no idle gap.
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   ena        global enable; when low every register holds and tx_out holds
//   up         nibble handshake (slave side)
//   tx_out     serial line, idle high
//   busy       high in START, DATA and STOP
//   frame_done one-cycle pulse on the last cycle of each frame

module hamming_encoder_74_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  hamming_encoder_74_tx_if.slave up,
  output logic                   tx_out,
  output logic                   busy,
  output logic                   frame_done
);

  localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [2:0] DATA_LAST = 3'd6;
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] baud_cnt, baud_nxt;
  logic [2:0] bit_cnt, bit_nxt;
  logic [6:0] shift, shift_nxt;
  logic [3:0] hold_data, hold_data_nxt;
  logic       hold_full, hold_full_nxt;
  logic       bit_end;
  logic       load;
  logic       accept;

  // cw = {d4,d3,d2,p3,d1,p2,p1}
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic p1, p2, p3;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p3 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p3, d[0], p2, p1};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      hold_data <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_nxt;
      baud_cnt  <= baud_nxt;
      bit_cnt   <= bit_nxt;
      shift     <= shift_nxt;
      hold_data <= hold_data_nxt;
      hold_full <= hold_full_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    baud_nxt      = baud_cnt;
    bit_nxt       = bit_cnt;
    shift_nxt     = shift;
    hold_data_nxt = hold_data;
    hold_full_nxt = hold_full;
    load          = 1'b0;
    frame_done    = 1'b0;

    // data_ready excludes a full holding register, so accept and load never
    // target the holding register in the same cycle
    up.data_ready = !hold_full && ena;
    accept        = up.data_valid && up.data_ready;
    bit_end       = (baud_cnt == BAUD_LAST);
    busy          = (state != IDLE);

    case (state)
      START:   tx_out = 1'b0;
      DATA:    tx_out = shift[0];
      default: tx_out = 1'b1;
    endcase

    if (ena) begin
      case (state)
        IDLE: begin
          if (hold_full) load = 1'b1;
        end
        START: begin
          if (bit_end) begin
            baud_nxt  = '0;
            bit_nxt   = '0;
            state_nxt = DATA;
          end else begin
            baud_nxt = baud_cnt + 8'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_nxt  = '0;
            shift_nxt = shift >> 1;
            if (bit_cnt == DATA_LAST) begin
              bit_nxt   = '0;
              state_nxt = STOP;
            end else begin
              bit_nxt = bit_cnt + 3'd1;
            end
          end else begin
            baud_nxt = baud_cnt + 8'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_nxt = '0;
            if (bit_cnt == STOP_LAST) begin
              frame_done = 1'b1;
              bit_nxt    = '0;
              // reload straight into START keeps back-to-back frames gapless
              if (hold_full) load = 1'b1;
              else           state_nxt = IDLE;
            end else begin
              bit_nxt = bit_cnt + 3'd1;
            end
          end else begin
            baud_nxt = baud_cnt + 8'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase

      if (load) begin
        shift_nxt     = encode(hold_data);
        hold_full_nxt = 1'b0;
        state_nxt     = START;
        baud_nxt      = '0;
        bit_nxt       = '0;
      end

      if (accept) begin
        hold_data_nxt = up.data_in;
        hold_full_nxt = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hamming_encoder_74_tx.sv
// tb/tb_hamming_encoder_74_tx.sv - scoreboard bench for hamming_encoder_74_tx

module tb_hamming_encoder_74_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  always #5 clk = ~clk;

  hamming_encoder_74_tx_if ifa ();
  hamming_encoder_74_tx_if ifb ();

  logic tx_a, busy_a, fd_a;
  logic tx_b, busy_b, fd_b;

  hamming_encoder_74_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .up(ifa),
    .tx_out(tx_a), .busy(busy_a), .frame_done(fd_a)
  );

  hamming_encoder_74_tx #(.CLKS_PER_BIT(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .up(ifb),
    .tx_out(tx_b), .busy(busy_b), .frame_done(fd_b)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [6:0] exp_a[$];
  logic [6:0] exp_b[$];
  int done_a[$];
  int done_b[$];

  bit          rx_act[2];
  int          rx_c[2];
  int          rx_start[2];
  int          last_len[2];
  bit          rx_bad[2];
  logic [10:0] rx_bits[2];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: classic positional Hamming code. Positions 1..7, parity at
  // powers of two, data filling the others in order; parity at 2^j covers
  // every position whose index has bit j set. cw[i] is position i+1.
  function automatic logic [6:0] model_cw(input logic [3:0] d);
    logic [7:1] pos;
    int di;
    logic par;
    di = 0;
    for (int p = 1; p <= 7; p++) begin
      if ((p & (p - 1)) == 0) pos[p] = 1'b0;
      else begin
        pos[p] = d[di];
        di++;
      end
    end
    for (int j = 0; j < 3; j++) begin
      par = 1'b0;
      for (int p = 1; p <= 7; p++)
        if (((p >> j) & 1) == 1) par = par ^ pos[p];
      pos[1 << j] = par;
    end
    return pos;
  endfunction

  // Serial receiver: counts only enabled cycles, so a frozen DUT looks like a
  // normal frame; all cycles of one bit must show the same level.
  task automatic rx_step(input int k, input logic tx, input logic bz, input logic fd);
    int cpb, sb, total, b;
    logic [6:0] e;
    bit have, framing;
    cpb = (k == 0) ? 4 : 1;
    sb = (k == 0) ? 1 : 2;
    total = (8 + sb) * cpb;
    if (!ena) return;
    if (!rx_act[k]) begin
      if (tx !== 1'b0) return;
      rx_act[k] = 1'b1;
      rx_c[k] = 0;
      rx_start[k] = cyc;
      rx_bad[k] = 1'b0;
      rx_bits[k] = '1;
    end
    b = rx_c[k] / cpb;
    if (rx_c[k] % cpb == 0) rx_bits[k][b] = tx;
    else if (tx !== rx_bits[k][b]) rx_bad[k] = 1'b1;
    if (bz !== 1'b1) rx_bad[k] = 1'b1;
    if (rx_c[k] == total - 1) begin
      check($sformatf("frame_done_at_end[%0d]", k), int'(fd), 1);
      check($sformatf("bit_stable_busy[%0d]", k), int'(rx_bad[k]), 0);
      framing = (rx_bits[k][0] == 1'b0) && (rx_bits[k][8] == 1'b1) &&
                (sb == 1 || rx_bits[k][9] == 1'b1);
      check($sformatf("framing[%0d]", k), int'(framing), 1);
      have = 1'b0;
      e = '0;
      if (k == 0 && exp_a.size() > 0) begin e = exp_a.pop_front(); have = 1'b1; end
      if (k == 1 && exp_b.size() > 0) begin e = exp_b.pop_front(); have = 1'b1; end
      check($sformatf("frame_expected[%0d]", k), int'(have), 1);
      if (have) check($sformatf("codeword[%0d]", k), int'(rx_bits[k][7:1]), int'(e));
      if (k == 0) done_a.push_back(cyc);
      else        done_b.push_back(cyc);
      last_len[k] = cyc - rx_start[k] + 1;
      rx_act[k] = 1'b0;
    end else begin
      if (fd !== 1'b0) rx_bad[k] = 1'b1;
      rx_c[k]++;
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc > 60000) begin
      $display("FAIL watchdog: got %0d cycles, expected under 60000", cyc);
      $fatal(1);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_act[0] = 1'b0;
      rx_act[1] = 1'b0;
      exp_a.delete();
      exp_b.delete();
    end else begin
      rx_step(0, tx_a, busy_a, fd_a);
      rx_step(1, tx_b, busy_b, fd_b);
    end
  end

  // Inputs change 2 ns after posedge; data_ready is sampled at the negedge
  // and the transfer happens on the following posedge.
  task automatic send(input int k, input logic [3:0] n, output int acc_cyc);
    bit ok;
    ok = 1'b0;
    acc_cyc = -1;
    @(posedge clk); #2;
    if (k == 0) begin ifa.data_in = n; ifa.data_valid = 1'b1; end
    else        begin ifb.data_in = n; ifb.data_valid = 1'b1; end
    for (int w = 0; w < 3000 && !ok; w++) begin
      @(negedge clk);
      ok = (k == 0) ? ifa.data_ready : ifb.data_ready;
    end
    if (!ok) check("send_timeout", 0, 1);
    else begin
      acc_cyc = cyc;
      if (k == 0) exp_a.push_back(model_cw(n));
      else        exp_b.push_back(model_cw(n));
    end
  endtask

  task automatic idle(input int k);
    @(posedge clk); #2;
    if (k == 0) ifa.data_valid = 1'b0;
    else        ifb.data_valid = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    bit done;
    done = 1'b0;
    for (int w = 0; w < 5000 && !done; w++) begin
      @(posedge clk); #2;
      done = !rx_act[k] && ((k == 0) ? exp_a.size() == 0 : exp_b.size() == 0);
    end
    check($sformatf("drain[%0d]", k), int'(done), 1);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic wait_rx(input int k, input int c);
    bit got;
    got = 1'b0;
    for (int w = 0; w < 2000 && !got; w++) begin
      @(posedge clk); #2;
      got = rx_act[k] && rx_c[k] >= c;
    end
    check("wait_rx_timeout", int'(got), 1);
  endtask

  initial begin
    int acc, acc3, base;
    logic [3:0] n2;
    logic ref_tx;
    int perm[16];
    int tmp, j;

    ifa.data_in = '0; ifa.data_valid = 1'b0;
    ifb.data_in = '0; ifb.data_valid = 1'b0;
    ena = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_tx_a", int'(tx_a), 1);
    check("rst_busy_a", int'(busy_a), 0);
    check("rst_fd_a", int'(fd_a), 0);
    check("rst_ready_a", int'(ifa.data_ready), 1);
    check("rst_tx_b", int'(tx_b), 1);
    check("rst_busy_b", int'(busy_b), 0);
    check("rst_fd_b", int'(fd_b), 0);
    check("rst_ready_b", int'(ifb.data_ready), 1);

    // single frame, 4'hB
    send(0, 4'hB, acc);
    idle(0);
    wait_idle(0);
    check("single_frame_len", last_len[0], 36);

    // back-to-back with valid held high
    base = done_a.size();
    send(0, 4'h0, acc);
    send(0, 4'hF, acc);
    idle(0);
    wait_idle(0);
    check("b2b_gap", done_a[base + 1] - done_a[base], 36);

    // three nibbles, third stalls until frame 1 reloads
    base = done_a.size();
    send(0, 4'($urandom), acc);
    send(0, 4'($urandom), acc);
    send(0, 4'($urandom), acc3);
    idle(0);
    wait_idle(0);
    check("third_accept_after_done", acc3 - done_a[base], 1);
    check("three_frames", done_a.size() - base, 3);

    // random traffic with random gaps
    for (int i = 0; i < 6; i++) begin
      send(0, 4'($urandom), acc);
      if ($urandom_range(0, 1) == 1) begin
        idle(0);
        repeat ($urandom_range(0, 40)) @(posedge clk);
      end
    end
    idle(0);
    wait_idle(0);

    // ena low for 10 cycles mid-DATA
    send(0, 4'($urandom), acc);
    idle(0);
    wait_rx(0, 12);
    ref_tx = tx_a;
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("ena_low_tx_hold", int'(tx_a), int'(ref_tx));
      check("ena_low_ready", int'(ifa.data_ready), 0);
      check("ena_low_fd", int'(fd_a), 0);
    end
    @(posedge clk); #2;
    ena = 1'b1;
    wait_idle(0);
    check("ena_stretch_len", last_len[0], 46);

    // reset during data bit 3 with a nibble held
    n2 = 4'($urandom);
    send(0, 4'($urandom), acc);
    send(0, n2, acc);
    idle(0);
    wait_rx(0, 17);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_tx", int'(tx_a), 1);
    check("midrst_busy", int'(busy_a), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_tx", int'(tx_a), 1);
    check("post_rst_busy", int'(busy_a), 0);
    check("post_rst_ready", int'(ifa.data_ready), 1);
    base = done_a.size();
    send(0, n2 ^ 4'h5, acc);
    idle(0);
    wait_idle(0);
    repeat (60) @(posedge clk);
    check("post_rst_frames", done_a.size() - base, 1);

    // exhaustive, CLKS_PER_BIT=1, STOP_BITS=2, shuffled order
    for (int i = 0; i < 16; i++) perm[i] = i;
    for (int i = 15; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    base = done_b.size();
    for (int i = 0; i < 16; i++) send(1, 4'(perm[i]), acc);
    idle(1);
    wait_idle(1);
    check("exh_frames", done_b.size() - base, 16);
    check("exh_len", last_len[1], 10);
    for (int i = 1; i < 16; i++)
      if (base + i < done_b.size())
        check("exh_gap", done_b[base + i] - done_b[base + i - 1], 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
